exe_div_unit: RTL and testbench

- Iterative radix-2 restoring divider in the EXE stage, fed directly by the ID/EXE pipeline register outputs (is_div, is_sign_div, rf_rdata0, rf_rdata1).
- Produces a 32-bit quotient for LO and a 32-bit remainder for HI.
- Holds the pipeline through a stall request while the division runs.
- Abandons the operation when the pipeline is flushed.

---
 rtl/exe_div_unit_if.sv | 25 ++
 rtl/exe_div_unit.sv | 129 ++++++++++++
 tb/tb_exe_div_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/exe_div_unit_if.sv
// Pipeline-side bundle of the EXE-stage divider: ID/EXE operands in, LO/HI results and stall out.
interface exe_div_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              cancel;
    logic              hold;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              result_valid;
    logic              div_stall;

    modport master (
        output start, is_signed, dividend, divisor, cancel, hold,
        input  quotient, remainder, result_valid, div_stall
    );

    modport slave (
        input  start, is_signed, dividend, divisor, cancel, hold,
        output quotient, remainder, result_valid, div_stall
    );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for the EXE stage: quotient to LO, remainder to HI.
//   state | meaning
//   IDLE  | waiting for a div from ID/EXE; stall follows start combinationally
//   BUSY  | one quotient bit per cycle, 32 cycles, pipeline stalled
//   DONE  | result presented; held while downstream stalls
module exe_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    exe_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  rem_q, dvd_q, dsr_q;
    logic [DATA_W-1:0]  quo_out, rem_out;
    logic               neg_quo, neg_rem;
    logic [CNT_W-1:0]   cnt;

    logic               dvd_neg, dsr_neg;
    logic [DATA_W-1:0]  dvd_abs, dsr_abs;
    logic [DATA_W:0]    shifted;
    logic               fits;
    logic [DATA_W-1:0]  rem_step, dvd_step;
    logic               last_iter;
    logic               div_zero;

    always_comb begin
        dvd_neg   = bus.is_signed & bus.dividend[DATA_W-1];
        dsr_neg   = bus.is_signed & bus.divisor[DATA_W-1];
        dvd_abs   = dvd_neg ? -bus.dividend : bus.dividend;
        dsr_abs   = dsr_neg ? -bus.divisor  : bus.divisor;
        div_zero  = (bus.divisor == '0);
        shifted   = {rem_q, dvd_q[DATA_W-1]};
        fits      = (shifted >= {1'b0, dsr_q});
        // A kept difference is always below the divisor, so 32-bit wraparound is exact.
        rem_step  = fits ? (shifted[DATA_W-1:0] - dsr_q) : shifted[DATA_W-1:0];
        dvd_step  = {dvd_q[DATA_W-2:0], fits};
        last_iter = (cnt == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        bus.result_valid = 1'b0;
        bus.div_stall    = 1'b0;
        case (state)
            IDLE: begin
                bus.div_stall = bus.start;
                if (bus.start) state_nxt = div_zero ? DONE : BUSY;
            end
            BUSY: begin
                bus.div_stall = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                bus.result_valid = 1'b1;
                if (!bus.hold) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start.
        if (bus.cancel) begin
            state_nxt        = IDLE;
            bus.result_valid = 1'b0;
            bus.div_stall    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_out <= '0;
            rem_out <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
        end else if (bus.cancel) begin
            quo_out <= '0;
            rem_out <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && div_zero) begin
                        quo_out <= '1;
                        rem_out <= bus.dividend;
                    end else if (bus.start) begin
                        rem_q   <= '0;
                        dvd_q   <= dvd_abs;
                        dsr_q   <= dsr_abs;
                        neg_quo <= dvd_neg ^ dsr_neg;
                        neg_rem <= dvd_neg;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    rem_q <= rem_step;
                    dvd_q <= dvd_step;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        quo_out <= neg_quo ? -dvd_step : dvd_step;
                        rem_out <= neg_rem ? -rem_step : rem_step;
                    end
                end
                DONE: begin
                    if (!bus.hold) begin
                        quo_out <= '0;
                        rem_out <= '0;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.quotient  = quo_out;
    assign bus.remainder = rem_out;

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: vector table with a result scoreboard plus flush/hold/reset sequences.
module tb_exe_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_div_unit_if #(.DATA_W(32)) bus ();

    exe_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          hold_n;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int hold_n);
        int   lat, stalls, lat_exp;
        logic seen;
        exp_t e;
        lat_exp = (b == 32'd0) ? 1 : 33;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.is_signed = sg; bus.dividend = a; bus.divisor = b;
        bus.hold = (hold_n > 0);
        e.q = eq; e.r = er;
        sb.push_back(e);
        @(negedge clk);
        stalls = bus.div_stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom);
        lat = 1; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (bus.result_valid) seen = 1'b1;
            else begin
                stalls += bus.div_stall ? 1 : 0;
                lat++;
            end
        end
        check("latency", lat, lat_exp);
        check("stall_cycles", stalls, lat_exp);
        if (!seen) begin
            check("result_valid_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            check("stall_in_done", {31'd0, bus.div_stall}, 32'd0);
            if (sb.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
            else begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                for (int i = 1; i <= hold_n; i++) begin
                    @(posedge clk); #1;
                    if (i == hold_n) bus.hold = 1'b0;
                    @(negedge clk);
                    check("hold_valid", {31'd0, bus.result_valid}, 32'd1);
                    check("hold_quotient", bus.quotient, e.q);
                    check("hold_remainder", bus.remainder, e.r);
                end
            end
        end
        @(posedge clk); #1;
        bus.hold = 1'b0;
        @(negedge clk);
        check("idle_valid", {31'd0, bus.result_valid}, 32'd0);
        check("idle_quotient", bus.quotient, 32'd0);
        check("idle_remainder", bus.remainder, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
        vecs[4]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   0};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          3};
        vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   0};
        vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          0};
        vecs[10] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1};
        vecs[11] = '{1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          0};

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
        bus.cancel = 1'b0; bus.hold = 1'b0;
        #1;
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset_stall", {31'd0, bus.div_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++)
            do_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hold_n);

        // flush in the middle of BUSY, then an immediate new division
        @(posedge clk); #1;
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(negedge clk);
        check("cancel_stall_T", {31'd0, bus.div_stall}, 32'd1);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall_T10", {31'd0, bus.div_stall}, 32'd0);
        check("cancel_valid_T10", {31'd0, bus.result_valid}, 32'd0);
        @(posedge clk); #1 bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_stall_T11", {31'd0, bus.div_stall}, 32'd0);
        do_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 0);

        // start and flush in the same cycle
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        check("same_cycle_stall", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        cnt = 0;
        repeat (36) begin
            @(negedge clk);
            if (bus.result_valid || bus.div_stall) cnt++;
        end
        check("same_cycle_activity", cnt, 32'd0);

        // asynchronous reset between edges in the middle of an operation
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_stall", {31'd0, bus.div_stall}, 32'd0);
        check("async_rst_valid", {31'd0, bus.result_valid}, 32'd0);
        check("async_rst_quotient", bus.quotient, 32'd0);
        check("async_rst_remainder", bus.remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid || bus.div_stall) cnt++;
        end
        check("post_rst_activity", cnt, 32'd0);

        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
